// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions, FSM encoding and flag packing for alu_seq.
package alu_pkg;

  localparam logic [2:0] OP_SUB   = 3'b000;
  localparam logic [2:0] OP_NAND  = 3'b001;
  localparam logic [2:0] OP_LONES = 3'b010;
  localparam logic [2:0] OP_OHDEC = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_ACC   = 3'b101;
  localparam logic [2:0] OP_CLR   = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  localparam int FLAG_ERR = 0;
  localparam int FLAG_NEG = 1;
  localparam int FLAG_POS = 2;
  localparam int FLAG_OVF = 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  // ERR masks every other flag; NEG/POS follow the sign of a non-zero result.
  function automatic logic [3:0] make_flags(input logic neg, input logic nonzero,
                                            input logic ovf, input logic err);
    logic [3:0] f;
    f = 4'b0000;
    if (err) begin
      f[FLAG_ERR] = 1'b1;
    end else begin
      f[FLAG_NEG] = neg;
      f[FLAG_POS] = ~neg & nonzero;
      f[FLAG_OVF] = ovf;
    end
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential signed shift-add multiplier: one partial product per cycle on magnitudes,
// sign applied to the final sum. done is a combinational pulse on the last iteration.
module alu_mul_seq import alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]      CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [CW-1:0]      cnt_r;
  logic               busy_r;
  logic               neg_r;
  logic [2*WIDTH-1:0] sum_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [2*WIDTH-1:0] step_s;

  // Magnitudes (the most negative value maps to its unsigned magnitude) and one iteration.
  always_comb begin
    mag_a_s = a[WIDTH-1] ? (~a + ONE_W) : a;
    mag_b_s = b[WIDTH-1] ? (~b + ONE_W) : b;
    step_s  = sum_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
    product = neg_r ? (~step_s + ONE_2W) : step_s;
    done    = busy_r && (cnt_r == {CW{1'b0}});
    busy    = busy_r;
  end

  // Operand load on start, then WIDTH shift-add iterations counted down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r   <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      neg_r    <= 1'b0;
      sum_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
    end else if (start && !busy_r) begin
      busy_r   <= 1'b1;
      cnt_r    <= CW'(WIDTH - 1);
      neg_r    <= a[WIDTH-1] ^ b[WIDTH-1];
      sum_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {{WIDTH{1'b0}}, mag_a_s};
      mplier_r <= mag_b_s;
    end else if (busy_r) begin
      sum_r    <= step_s;
      mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      if (cnt_r == {CW{1'b0}}) begin
        busy_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r - CNT_ONE;
      end
    end else begin
      busy_r <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked datapath ALU: single-cycle SUB/NAND/LONES/OHDEC/ACC/CLR and a
// WIDTH-cycle signed multiply, all results and flags registered.
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_arg0,
  input  logic [WIDTH-1:0] i_arg1,
  input  logic [2:0]       i_oper,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flag
);

  localparam int CNTW = $clog2(2*WIDTH + 1);
  localparam int IDXW = $clog2(2*WIDTH);
  localparam logic [CNTW-1:0]  CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_r, state_nx_s;
  logic               ready_s, accept_op_s, mul_start_s;
  logic               mul_busy_s, mul_done_s;
  logic [2*WIDTH-1:0] mul_prod_s;
  logic [WIDTH-1:0]   mul_res_s;
  logic [3:0]         mul_flag_s;
  logic [WIDTH-1:0]   acc_r, acc_nx_s;
  logic [WIDTH-1:0]   op_res_s, diff_s;
  logic [3:0]         op_flag_s;
  logic               op_err_s, op_ovf_s, run_s;
  logic [2*WIDTH-1:0] cat_s;
  logic [CNTW-1:0]    lones_s, ones_s;
  logic [IDXW-1:0]    idx_s;
  logic [WIDTH:0]     acc_sum_s;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (i_clk),
    .rst_n   (i_rstn),
    .start   (mul_start_s),
    .a       (i_arg0),
    .b       (i_arg1),
    .busy    (mul_busy_s),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state; BUSY also falls back to IDLE should the multiplier ever be idle.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (mul_start_s) state_nx_s = S_BUSY;
        else             state_nx_s = S_IDLE;
      end
      S_BUSY: begin
        if (mul_done_s || !mul_busy_s) state_nx_s = S_IDLE;
        else                           state_nx_s = S_BUSY;
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // FSM outputs: handshake and request steering.
  always_comb begin
    ready_s     = (state_r == S_IDLE);
    accept_op_s = i_valid && ready_s && (i_oper != OP_MUL);
    mul_start_s = i_valid && ready_s && (i_oper == OP_MUL);
    o_ready     = ready_s;
  end

  // Leading-ones count and one-hot index over {B,A}.
  always_comb begin
    cat_s   = {i_arg1, i_arg0};
    lones_s = {CNTW{1'b0}};
    ones_s  = {CNTW{1'b0}};
    idx_s   = {IDXW{1'b0}};
    run_s   = 1'b1;
    for (int i = 2*WIDTH-1; i >= 0; i--) begin
      if (run_s && cat_s[i]) lones_s = lones_s + CNT_ONE;
      else                   run_s   = 1'b0;
      if (cat_s[i]) begin
        ones_s = ones_s + CNT_ONE;
        idx_s  = IDXW'(i);
      end else begin
        ones_s = ones_s;
      end
    end
  end

  // Single-cycle operations and accumulator update.
  always_comb begin
    op_res_s  = {WIDTH{1'b0}};
    op_err_s  = 1'b0;
    op_ovf_s  = 1'b0;
    acc_nx_s  = acc_r;
    diff_s    = i_arg1 - i_arg0;
    acc_sum_s = {acc_r[WIDTH-1], acc_r} + {i_arg0[WIDTH-1], i_arg0};
    case (i_oper)
      OP_SUB: begin
        op_res_s = diff_s;
        op_ovf_s = (i_arg0[WIDTH-1] != i_arg1[WIDTH-1]) && (diff_s[WIDTH-1] != i_arg1[WIDTH-1]);
      end
      OP_NAND:  op_res_s = ~(i_arg0 & i_arg1);
      OP_LONES: op_res_s = WIDTH'(lones_s);
      OP_OHDEC: begin
        if (ones_s == CNT_ONE) op_res_s = WIDTH'(idx_s);
        else                   op_err_s = 1'b1;
      end
      OP_MUL:   op_res_s = {WIDTH{1'b0}};
      OP_ACC: begin
        if (acc_sum_s[WIDTH] != acc_sum_s[WIDTH-1]) begin
          acc_nx_s = acc_sum_s[WIDTH] ? ACC_MIN : ACC_MAX;
          op_ovf_s = 1'b1;
        end else begin
          acc_nx_s = acc_sum_s[WIDTH-1:0];
        end
        op_res_s = acc_nx_s;
      end
      OP_CLR:   acc_nx_s = {WIDTH{1'b0}};
      OP_RSVD:  op_err_s = 1'b1;
      default:  op_err_s = 1'b1;
    endcase
    op_flag_s = make_flags(op_res_s[WIDTH-1], |op_res_s, op_ovf_s, op_err_s);
  end

  // Product truncation; overflow when the upper WIDTH+1 bits are not a sign extension.
  always_comb begin
    mul_res_s  = mul_prod_s[WIDTH-1:0];
    mul_flag_s = make_flags(mul_res_s[WIDTH-1], |mul_res_s,
                            !((&mul_prod_s[2*WIDTH-1:WIDTH-1]) || ~(|mul_prod_s[2*WIDTH-1:WIDTH-1])),
                            1'b0);
  end

  // Registered result, flags, valid pulse and accumulator.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_valid  <= 1'b0;
      o_result <= {WIDTH{1'b0}};
      o_flag   <= 4'b0000;
      acc_r    <= {WIDTH{1'b0}};
    end else if (mul_done_s) begin
      o_valid  <= 1'b1;
      o_result <= mul_res_s;
      o_flag   <= mul_flag_s;
    end else if (accept_op_s) begin
      o_valid  <= 1'b1;
      o_result <= op_res_s;
      o_flag   <= op_flag_s;
      acc_r    <= acc_nx_s;
    end else begin
      o_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8 with hand-computed expectations.
module tb_alu_seq;

  logic       clk;
  logic       i_rstn;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_arg0;
  logic [7:0] i_arg1;
  logic [2:0] i_oper;
  logic       o_valid;
  logic [7:0] o_result;
  logic [3:0] o_flag;

  int n_total = 0;
  int n_bad   = 0;

  alu_seq #(.WIDTH(8)) dut (
    .i_clk    (clk),
    .i_rstn   (i_rstn),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_arg0   (i_arg0),
    .i_arg1   (i_arg1),
    .i_oper   (i_oper),
    .o_valid  (o_valid),
    .o_result (o_result),
    .o_flag   (o_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op(input string tag, input logic [2:0] oper, input logic [7:0] a,
                    input logic [7:0] b, input logic [7:0] exp_res, input logic [3:0] exp_flag);
    @(negedge clk);
    i_oper = oper; i_arg0 = a; i_arg1 = b; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_res"}, 32'(o_result), 32'(exp_res));
    chk({tag, "_flag"}, 32'(o_flag), 32'(exp_flag));
  endtask

  task automatic mul_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_res, input logic [3:0] exp_flag, input bit disturb);
    int ready_low;
    int lat;
    ready_low = 0;
    lat = 0;
    @(negedge clk);
    i_oper = 3'b100; i_arg0 = a; i_arg1 = b; i_valid = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (o_valid) begin
        lat = n;
        break;
      end
      if (!o_ready) ready_low++;
      if (disturb && n >= 2 && n <= 5) begin
        i_valid = 1'b1; i_oper = 3'b000;
        i_arg0 = 8'(n * 37); i_arg1 = 8'(n * 11);
      end else begin
        i_valid = 1'b0;
      end
    end
    i_valid = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'd9);
    chk({tag, "_ready_low"}, 32'(ready_low), 32'd8);
    chk({tag, "_ready_back"}, 32'(o_ready), 32'd1);
    chk({tag, "_res"}, 32'(o_result), 32'(exp_res));
    chk({tag, "_flag"}, 32'(o_flag), 32'(exp_flag));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(o_valid), 32'd0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flag;
  } nand_vec_t;

  nand_vec_t nv[5];
  int vpulses;

  initial begin
    nv[0] = '{8'hFF, 8'hFF, 8'h00, 4'b0000};
    nv[1] = '{8'h00, 8'h00, 8'hFF, 4'b0010};
    nv[2] = '{8'h7F, 8'hFF, 8'h80, 4'b0010};
    nv[3] = '{8'h80, 8'h80, 8'h7F, 4'b0100};
    nv[4] = '{8'h0F, 8'h0E, 8'hF1, 4'b0010};

    i_rstn = 1'b0; i_valid = 1'b0; i_arg0 = 8'h00; i_arg1 = 8'h00; i_oper = 3'b000;
    #1;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_res", 32'(o_result), 32'd0);
    chk("rst_flag", 32'(o_flag), 32'd0);
    @(negedge clk);
    i_rstn = 1'b1;

    op("sub_pos", 3'b000, 8'd4, 8'd7, 8'h03, 4'b0100);
    op("sub_ovf", 3'b000, 8'hFF, 8'h7F, 8'h80, 4'b1010);
    op("nand", 3'b001, 8'hF0, 8'h3C, 8'hCF, 4'b0010);
    op("lones", 3'b010, 8'hC3, 8'hFF, 8'h0A, 4'b0100);
    op("ohdec", 3'b011, 8'h00, 8'h04, 8'h0A, 4'b0100);
    op("ohdec_multi", 3'b011, 8'h03, 8'h00, 8'h00, 4'b0001);
    op("ohdec_zero", 3'b011, 8'h00, 8'h00, 8'h00, 4'b0001);

    mul_op("mul_neg", 8'd12, 8'hFB, 8'hC4, 4'b0010, 1'b0);
    mul_op("mul_ovf", 8'd100, 8'd3, 8'h2C, 4'b1100, 1'b0);
    mul_op("mul_minmin", 8'h80, 8'h80, 8'h00, 4'b1000, 1'b0);
    mul_op("mul_min1", 8'h80, 8'h01, 8'h80, 4'b0010, 1'b0);
    mul_op("mul_busy_ign", 8'd12, 8'hFB, 8'hC4, 4'b0010, 1'b1);

    op("clr", 3'b110, 8'h55, 8'h55, 8'h00, 4'b0000);
    op("acc1", 3'b101, 8'd100, 8'h00, 8'd100, 4'b0100);
    op("acc_sat_hi", 3'b101, 8'd100, 8'h00, 8'h7F, 4'b1100);
    op("acc_m128", 3'b101, 8'h80, 8'h00, 8'hFF, 4'b0010);
    op("acc_sat_lo", 3'b101, 8'h80, 8'h00, 8'h80, 4'b1010);
    op("rsvd", 3'b111, 8'h05, 8'h05, 8'h00, 4'b0001);
    op("acc_after_rsvd", 3'b101, 8'h01, 8'h00, 8'h81, 4'b0010);

    // Five NANDs accepted on consecutive edges.
    @(negedge clk);
    i_oper = 3'b001; i_arg0 = nv[0].a; i_arg1 = nv[0].b; i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("b2b%0d_valid", i), 32'(o_valid), 32'd1);
      chk($sformatf("b2b%0d_res", i), 32'(o_result), 32'(nv[i].res));
      chk($sformatf("b2b%0d_flag", i), 32'(o_flag), 32'(nv[i].flag));
      if (i < 4) begin
        i_arg0 = nv[i+1].a; i_arg1 = nv[i+1].b;
      end else begin
        i_valid = 1'b0;
      end
    end

    // Reset three cycles into a multiply.
    @(negedge clk);
    i_oper = 3'b100; i_arg0 = 8'd12; i_arg1 = 8'hFB; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_mul_busy", 32'(o_ready), 32'd0);
    #2 i_rstn = 1'b0;
    #1;
    chk("arst_ready", 32'(o_ready), 32'd1);
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_res", 32'(o_result), 32'd0);
    chk("arst_flag", 32'(o_flag), 32'd0);
    @(negedge clk);
    @(negedge clk);
    i_rstn = 1'b1;
    vpulses = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (o_valid) vpulses++;
    end
    chk("arst_no_valid", 32'(vpulses), 32'd0);
    op("arst_acc", 3'b101, 8'h00, 8'h00, 8'h00, 4'b0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
